// File: rtl/axis_spm_vector_gen.sv
// ---------------------------------------------------------------------------------------------
// axis_spm_vector_gen
//
// Vector stepper that produces the Xs/Ys/Zs/U component streams for the SPM control stage.
// A start loads each accumulator with its start coordinate. The vector then advances by a
// signed fractional increment per point, and each point is held for a programmable dwell.
// The streams are sampled continuously downstream, so tvalid rises with the first start and
// stays high until reset. Outputs hold their value while idle.
//
// Optional feature:
//   SPM_VECGEN_SATURATE_EN  defined   -> accumulators clamp to integer range
//                                        [-(2^(W-1)-1), 2^(W-1)-1]
//                           undefined -> two's-complement wrap-around
//
// Ports:
//   a_clk, a_rst              clock, asynchronous active-high reset
//   start, abort              level-sampled control
//   x/y/z/u_start             signed start coordinates (output LSB units)
//   dx/dy/dz/du               signed per-point increments, Q(QFRAC)
//   n_points, dwell           point count and clocks per point (0 is treated as 1)
//   M_AXIS_*_tdata/_tvalid    component streams
//   busy, done, point_index   status for the PS register bank
// ---------------------------------------------------------------------------------------------
module axis_spm_vector_gen #(
   parameter int unsigned SAXIS_TDATA_WIDTH = 32,
   parameter int unsigned QFRAC             = 16
) (
   input  logic                                a_clk,
   input  logic                                a_rst,
   input  logic                                start,
   input  logic                                abort,
   input  logic signed [SAXIS_TDATA_WIDTH-1:0] x_start,
   input  logic signed [SAXIS_TDATA_WIDTH-1:0] y_start,
   input  logic signed [SAXIS_TDATA_WIDTH-1:0] z_start,
   input  logic signed [SAXIS_TDATA_WIDTH-1:0] u_start,
   input  logic signed [31:0]                  dx,
   input  logic signed [31:0]                  dy,
   input  logic signed [31:0]                  dz,
   input  logic signed [31:0]                  du,
   input  logic        [31:0]                  n_points,
   input  logic        [31:0]                  dwell,
   output logic        [SAXIS_TDATA_WIDTH-1:0] M_AXIS_Xs_tdata,
   output logic                                M_AXIS_Xs_tvalid,
   output logic        [SAXIS_TDATA_WIDTH-1:0] M_AXIS_Ys_tdata,
   output logic                                M_AXIS_Ys_tvalid,
   output logic        [SAXIS_TDATA_WIDTH-1:0] M_AXIS_Zs_tdata,
   output logic                                M_AXIS_Zs_tvalid,
   output logic        [SAXIS_TDATA_WIDTH-1:0] M_AXIS_U_tdata,
   output logic                                M_AXIS_U_tvalid,
   output logic                                busy,
   output logic                                done,
   output logic        [31:0]                  point_index
);

   localparam int unsigned AW = SAXIS_TDATA_WIDTH + QFRAC;  // accumulator width
   localparam int unsigned SW = AW + 1;                     // sum width, one guard bit

`ifdef SPM_VECGEN_SATURATE_EN
   // Largest value whose integer part is +max, and the clamp points with zero fraction.
   localparam logic signed [SW-1:0] LimHi =
      {2'b00, {(SAXIS_TDATA_WIDTH-1){1'b1}}, {QFRAC{1'b1}}};
   localparam logic signed [SW-1:0] SatHi =
      {2'b00, {(SAXIS_TDATA_WIDTH-1){1'b1}}, {QFRAC{1'b0}}};
   localparam logic signed [SW-1:0] SatLo = -SatHi;
`endif

   typedef enum logic {StIdle, StRun} state_e;

   state_e                 state_q;
   logic signed [AW-1:0]   acc_x_q, acc_y_q, acc_z_q, acc_u_q;
   logic signed [31:0]     dx_q, dy_q, dz_q, du_q;
   logic        [31:0]     last_q;   // index of the final point
   logic        [31:0]     dwell_q;  // reload value, never 0
   logic        [31:0]     cnt_q;
   logic        [31:0]     point_q;
   logic                   tvalid_q, busy_q, done_q;

   logic        [31:0]     dwell_eff, last_eff;

   assign dwell_eff = (dwell == 32'd0) ? 32'd1 : dwell;
   assign last_eff  = (n_points == 32'd0) ? 32'd0 : n_points - 32'd1;

   function automatic logic signed [AW-1:0] acc_step(input logic signed [AW-1:0] acc,
                                                     input logic signed [31:0]   inc);
      logic signed [SW-1:0] sum;
      sum = SW'(acc) + SW'(inc);
`ifdef SPM_VECGEN_SATURATE_EN
      if (sum > LimHi) begin
         return SatHi[AW-1:0];
      end else if (sum < SatLo) begin
         return SatLo[AW-1:0];
      end
      return sum[AW-1:0];
`else
      // Plain wrap: the guard bit is dropped.
      return sum[AW-1:0];
`endif
   endfunction

   always_ff @(posedge a_clk or posedge a_rst) begin
      if (a_rst) begin
         state_q  <= StIdle;
         acc_x_q  <= '0;
         acc_y_q  <= '0;
         acc_z_q  <= '0;
         acc_u_q  <= '0;
         dx_q     <= '0;
         dy_q     <= '0;
         dz_q     <= '0;
         du_q     <= '0;
         last_q   <= '0;
         dwell_q  <= 32'd1;
         cnt_q    <= 32'd1;
         point_q  <= '0;
         tvalid_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (start && !abort) begin
                  acc_x_q  <= {x_start, {QFRAC{1'b0}}};
                  acc_y_q  <= {y_start, {QFRAC{1'b0}}};
                  acc_z_q  <= {z_start, {QFRAC{1'b0}}};
                  acc_u_q  <= {u_start, {QFRAC{1'b0}}};
                  dx_q     <= dx;
                  dy_q     <= dy;
                  dz_q     <= dz;
                  du_q     <= du;
                  last_q   <= last_eff;
                  dwell_q  <= dwell_eff;
                  cnt_q    <= dwell_eff;
                  point_q  <= '0;
                  tvalid_q <= 1'b1;
                  busy_q   <= 1'b1;
                  state_q  <= StRun;
               end
            end
            StRun: begin
               // Abort wins over both completion and stepping on the same edge.
               if (abort) begin
                  busy_q  <= 1'b0;
                  state_q <= StIdle;
               end else if (cnt_q != 32'd1) begin
                  cnt_q <= cnt_q - 32'd1;
               end else if (point_q == last_q) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= StIdle;
               end else begin
                  point_q <= point_q + 32'd1;
                  acc_x_q <= acc_step(acc_x_q, dx_q);
                  acc_y_q <= acc_step(acc_y_q, dy_q);
                  acc_z_q <= acc_step(acc_z_q, dz_q);
                  acc_u_q <= acc_step(acc_u_q, du_q);
                  cnt_q   <= dwell_q;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Integer part of each accumulator, i.e. floor of the fractional value.
   assign M_AXIS_Xs_tdata  = acc_x_q[QFRAC +: SAXIS_TDATA_WIDTH];
   assign M_AXIS_Ys_tdata  = acc_y_q[QFRAC +: SAXIS_TDATA_WIDTH];
   assign M_AXIS_Zs_tdata  = acc_z_q[QFRAC +: SAXIS_TDATA_WIDTH];
   assign M_AXIS_U_tdata   = acc_u_q[QFRAC +: SAXIS_TDATA_WIDTH];
   assign M_AXIS_Xs_tvalid = tvalid_q;
   assign M_AXIS_Ys_tvalid = tvalid_q;
   assign M_AXIS_Zs_tvalid = tvalid_q;
   assign M_AXIS_U_tvalid  = tvalid_q;
   assign busy             = busy_q;
   assign done             = done_q;
   assign point_index      = point_q;

endmodule

// File: tb/tb_axis_spm_vector_gen.sv
module tb_axis_spm_vector_gen;

   logic        a_clk = 1'b0;
   logic        a_rst;
   logic        start, abort;
   logic [31:0] x_start, y_start, z_start, u_start;
   logic [31:0] dx, dy, dz, du;
   logic [31:0] n_points, dwell;
   logic [31:0] xs_t, ys_t, zs_t, u_t;
   logic        xs_v, ys_v, zs_v, u_v;
   logic        busy, done;
   logic [31:0] point_index;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];
   logic [31:0] last_x;
   logic [31:0] ys_hold;

   always #5 a_clk = ~a_clk;

   axis_spm_vector_gen dut (
      .a_clk            (a_clk),
      .a_rst            (a_rst),
      .start            (start),
      .abort            (abort),
      .x_start          (x_start),
      .y_start          (y_start),
      .z_start          (z_start),
      .u_start          (u_start),
      .dx               (dx),
      .dy               (dy),
      .dz               (dz),
      .du               (du),
      .n_points         (n_points),
      .dwell            (dwell),
      .M_AXIS_Xs_tdata  (xs_t),
      .M_AXIS_Xs_tvalid (xs_v),
      .M_AXIS_Ys_tdata  (ys_t),
      .M_AXIS_Ys_tvalid (ys_v),
      .M_AXIS_Zs_tdata  (zs_t),
      .M_AXIS_Zs_tvalid (zs_v),
      .M_AXIS_U_tdata   (u_t),
      .M_AXIS_U_tvalid  (u_v),
      .busy             (busy),
      .done             (done),
      .point_index      (point_index)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      if (obs !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, expv);
      end
   endtask

   // Reference model of the X accumulator: one expected Xs value per clock.
   task automatic push_exp(input logic [31:0] xs, input logic [31:0] d, input int n,
                           input int dw, input int limit);
      longint acc;
      int     nn, dd, cnt;
      nn  = (n == 0) ? 1 : n;
      dd  = (dw == 0) ? 1 : dw;
      cnt = 0;
      acc = longint'(signed'(xs)) <<< 16;
      for (int p = 0; p < nn; p++) begin
         for (int c = 0; c < dd; c++) begin
            if (cnt < limit) begin
               exp_q.push_back(32'(acc >>> 16));
               cnt++;
            end
         end
         acc = acc + longint'(signed'(d));
`ifdef SPM_VECGEN_SATURATE_EN
         if ((acc >>> 16) > 64'sd2147483647) acc = 64'sd2147483647 <<< 16;
         else if ((acc >>> 16) < -64'sd2147483647) acc = -(64'sd2147483647 <<< 16);
`endif
      end
   endtask

   task automatic check_x(input string tag);
      logic [31:0] e;
      if (exp_q.size() == 0) begin
         check({tag, "_noexp"}, 64'd1, 64'd0);
      end else begin
         e      = exp_q.pop_front();
         last_x = e;
         check(tag, xs_t, e);
      end
   endtask

   // Drives one start; returns 1 ns after the sampling edge.
   task automatic drive(input logic [31:0] xs, input logic [31:0] d, input int n,
                        input int dw);
      @(posedge a_clk);
      #1;
      x_start  = xs;
      dx       = d;
      n_points = n;
      dwell    = dw;
      start    = 1'b1;
      push_exp(xs, d, n, dw, 1 << 30);
      @(posedge a_clk);
      #1;
      start = 1'b0;
   endtask

   task automatic run_check(input string tag, input int n, input int dw);
      int nn, dd;
      nn = (n == 0) ? 1 : n;
      dd = (dw == 0) ? 1 : dw;
      for (int j = 0; j < nn * dd; j++) begin
         @(negedge a_clk);
         check_x({tag, "_xs"});
         check({tag, "_busy"}, busy, 1'b1);
         check({tag, "_done_early"}, done, 1'b0);
         check({tag, "_pidx"}, point_index, 32'(j / dd));
         check({tag, "_tvalid"}, {xs_v, ys_v, zs_v, u_v}, 4'hF);
         check({tag, "_ys"}, ys_t, y_start);
         check({tag, "_zs"}, zs_t, z_start);
         check({tag, "_u"}, u_t, u_start);
      end
      @(negedge a_clk);
      check({tag, "_done"}, done, 1'b1);
      check({tag, "_busy_end"}, busy, 1'b0);
      check({tag, "_xs_hold"}, xs_t, last_x);
      @(negedge a_clk);
      check({tag, "_done_pulse"}, done, 1'b0);
      check({tag, "_xs_hold2"}, xs_t, last_x);
      check({tag, "_tvalid_hold"}, xs_v, 1'b1);
   endtask

   initial begin
      a_rst    = 1'b1;
      start    = 1'b0;
      abort    = 1'b0;
      x_start  = 32'd0;
      y_start  = 32'hFFFF_FFFB;
      z_start  = 32'd7;
      u_start  = 32'd3;
      dx       = 32'd0;
      dy       = 32'd0;
      dz       = 32'd0;
      du       = 32'd0;
      n_points = 32'd0;
      dwell    = 32'd0;
      #12;
      check("rst_xs", xs_t, 32'd0);
      check("rst_ys", ys_t, 32'd0);
      check("rst_tvalid", {xs_v, ys_v, zs_v, u_v}, 4'h0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_pidx", point_index, 32'd0);
      @(negedge a_clk);
      a_rst = 1'b0;
      @(negedge a_clk);
      check("idle_tvalid", xs_v, 1'b0);

      // Basic ramp
      drive(32'd100, 32'd10 << 16, 4, 3);
      run_check("ramp", 4, 3);

      // Fractional steps, positive and negative
      drive(32'd0, 32'h0000_8000, 5, 1);
      run_check("frac_pos", 5, 1);
      drive(32'd0, 32'hFFFF_8000, 5, 1);
      run_check("frac_neg", 5, 1);

      // Overflow: wrap or clamp depending on build
      drive(32'h7FFF_FFF0, 32'd16 << 16, 3, 1);
      run_check("ovf", 3, 1);

      // Abort with start held high and inputs changed mid-run
      @(posedge a_clk);
      #1;
      x_start  = 32'd500;
      dx       = 32'd3 << 16;
      n_points = 32'd10;
      dwell    = 32'd2;
      start    = 1'b1;
      ys_hold  = y_start;
      push_exp(32'd500, 32'd3 << 16, 10, 2, 10);
      @(posedge a_clk);
      #1;
      x_start = 32'd9999;
      dx      = 32'd77 << 16;
      y_start = 32'd1234;
      for (int j = 0; j < 10; j++) begin
         @(negedge a_clk);
         check_x("abort_xs");
         check("abort_pidx", point_index, 32'(j / 2));
         check("abort_busy", busy, 1'b1);
         check("abort_ys_latched", ys_t, ys_hold);
      end
      abort = 1'b1;  // lands on the edge that would otherwise step to point 5
      for (int j = 0; j < 2; j++) begin
         @(negedge a_clk);
         check("abort_frozen", xs_t, last_x);
         check("abort_pidx_hold", point_index, 32'd4);
         check("abort_busy_low", busy, 1'b0);
         check("abort_no_done", done, 1'b0);
      end
      @(posedge a_clk);
      #1;
      start   = 1'b0;
      abort   = 1'b0;
      y_start = ys_hold;
      @(negedge a_clk);
      check("abort_idle_xs", xs_t, last_x);
      check("abort_idle_busy", busy, 1'b0);

      // Restart reloads fresh start values
      drive(32'hFFFF_FFD8, 32'd5 << 16, 3, 2);
      run_check("restart", 3, 2);

      // Asynchronous reset mid-run
      drive(32'd1000, 32'd1 << 16, 10, 2);
      for (int j = 0; j < 7; j++) begin
         @(negedge a_clk);
         check_x("rstrun_xs");
      end
      check("rstrun_pidx", point_index, 32'd3);
      #2;
      a_rst = 1'b1;
      #1;
      check("rstrun_xs0", xs_t, 32'd0);
      check("rstrun_ys0", ys_t, 32'd0);
      check("rstrun_tvalid", {xs_v, ys_v, zs_v, u_v}, 4'h0);
      check("rstrun_busy", busy, 1'b0);
      check("rstrun_pidx0", point_index, 32'd0);
      exp_q.delete();
      @(negedge a_clk);
      a_rst = 1'b0;
      @(negedge a_clk);
      check("rstrun_tvalid_idle", xs_v, 1'b0);

      // Degenerate counts after reset; tvalid rises with this start
      drive(32'd55, 32'd7 << 16, 0, 0);
      run_check("degen", 0, 0);

      // Normal operation after reset
      drive(32'd20, 32'hFFFE_0000, 3, 2);
      run_check("post_rst", 3, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
